// File: rtl/sklansky_adder_pipe_pkg.sv
// Shared prefix-adder helpers: extended generate/propagate formation.
// Purely combinational; no latency.
// No handshake of its own; callers own flow control.
package sklansky_adder_pipe_pkg;

  // Widest operand the shared helper handles; tops zero-extend into it.
  // A top using it must keep WIDTH strictly below this value.
  localparam int PG_MAX_W = 128;

  // Returns {p, g}, each PG_MAX_W+1 bits. Bit 0 carries cin as a
  // generate with no propagate, so the prefix tree needs no separate carry-in.
  function automatic logic [2*PG_MAX_W+1:0] pg_ext(
    input logic [PG_MAX_W-1:0] a,
    input logic [PG_MAX_W-1:0] b,
    input logic                cin
  );
    logic [PG_MAX_W:0] g;
    logic [PG_MAX_W:0] p;
    g = {a & b, cin};
    p = {a ^ b, 1'b0};
    return {p, g};
  endfunction

endpackage

// File: rtl/sklansky_block.sv
// Sklansky parallel-prefix network producing group generate G[k] over bits k..0.
// Combinational; ceil(log2(N)) black-cell levels.
// No handshake; sits between pipeline registers.
module sklansky_block #(
  parameter int N = 33
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  output logic [N-1:0] grp_g
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] gv;
  logic [N-1:0] pv;

  // Level l: every bit with bit l of its index set absorbs the group ending
  // at the top of the lower half-block. That source bit never updates at the
  // same level, so updating in place is order-independent.
  always_comb begin
    gv = g;
    pv = p;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < N; i++) begin
        if (((i >> l) & 1) == 1) begin
          gv[i] = gv[i] | (pv[i] & gv[((i >> l) << l) - 1]);
          pv[i] = pv[i] & pv[((i >> l) << l) - 1];
        end
      end
    end
  end

  assign grp_g = gv;

endmodule

// File: rtl/sklansky_adder_pipe.sv
// Two-stage pipelined WIDTH-bit adder: PG formation -> S1 regs -> Sklansky tree -> S2 regs.
// Latency 2 clk edges from acceptance to out_valid; one result per cycle at full rate.
// Backpressure: S2 holds under out_ready=0, S1 still fills, then in_ready drops.
module sklansky_adder_pipe
  import sklansky_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [PG_MAX_W-1:0]       a_ext;
  logic [PG_MAX_W-1:0]       b_ext;
  logic [WIDTH:0]            g_ext;
  logic [WIDTH:0]            p_ext;
  logic [PG_MAX_W-WIDTH-1:0] g_unused;
  logic [PG_MAX_W-WIDTH-1:0] p_unused;

  logic             s1_valid;
  logic [WIDTH:0]   s1_g;
  logic [WIDTH:0]   s1_p;
  logic [WIDTH-1:0] s1_h;
  logic             s2_valid;
  logic [WIDTH:0]   grp_g;
  logic             s2_adv;
  logic             in_fire;

  assign a_ext = {{(PG_MAX_W-WIDTH){1'b0}}, a};
  assign b_ext = {{(PG_MAX_W-WIDTH){1'b0}}, b};
  assign {p_unused, p_ext, g_unused, g_ext} = pg_ext(a_ext, b_ext, cin);

  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Stage 1: capture extended PG and half-sum on input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_h     <= '0;
    end else begin
      s1_valid <= in_fire | (s1_valid & ~s2_adv);
      if (in_fire) begin
        s1_g <= g_ext;
        s1_p <= p_ext;
        s1_h <= a ^ b;
      end
    end
  end

  sklansky_block #(
    .N(WIDTH + 1)
  ) u_prefix (
    .g     (s1_g),
    .p     (s1_p),
    .grp_g (grp_g)
  );

  // Stage 2: carry into bit i is the group generate ending at extended bit i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      s2_valid <= s2_adv | (s2_valid & ~out_ready);
      if (s2_adv) begin
        sum  <= s1_h ^ grp_g[WIDTH-1:0];
        cout <= grp_g[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_sklansky_adder_pipe.sv
// Self-checking bench for sklansky_adder_pipe against a plain a+b+cin model.
// Drives inputs 1 time unit after rising edges, samples on falling edges.
// Covers reset, carry chains, backpressure, full-rate and random streaming, WIDTH=5.
module tb_sklansky_adder_pipe;

  localparam int W  = 32;
  localparam int W5 = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0]  a, b, sum;
  logic          in_valid5, in_ready5, cin5, out_valid5, out_ready5, cout5;
  logic [W5-1:0] a5, b5, sum5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sklansky_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  sklansky_adder_pipe #(.WIDTH(W5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .cin(cin5), .out_valid(out_valid5), .out_ready(out_ready5),
    .sum(sum5), .cout(cout5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = $urandom_range(1);
      out_ready = $urandom_range(1);
      @(negedge clk);
      checks++;
      if ({out_valid, cout, sum, in_ready} !== {1'b0, 1'b0, {W{1'b0}}, 1'b1}) begin
        failures++;
        $display("FAIL reset_state: got valid=%0b cout=%0b sum=%h rdy=%0b, want 0 0 0 1",
                 out_valid, cout, sum, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W:0]   exp_v;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 1'b0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vc[1] = 1'b1;
    va[2] = $urandom;      vb[2] = $urandom;      vc[2] = 1'b1;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = va[k]; b = vb[k]; cin = vc[k];
      exp_v = {1'b0, va[k]} + {1'b0, vb[k]} + {{W{1'b0}}, vc[k]};
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL chain_early_valid[%0d]: got %0b want 0", k, out_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({out_valid, cout, sum} !== {1'b1, exp_v}) begin
        failures++;
        $display("FAIL chain_result[%0d]: got valid=%0b cout=%0b sum=%h want 1 %0b %h",
                 k, out_valid, cout, sum, exp_v[W], exp_v[W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_width5();
    logic [W5-1:0] va [2];
    logic [W5-1:0] vb [2];
    logic          vc [2];
    logic [W5:0]   exp_v [2];
    va[0] = 5'd31; vb[0] = 5'd31; vc[0] = 1'b1; exp_v[0] = {1'b1, 5'd31};
    va[1] = 5'd16; vb[1] = 5'd16; vc[1] = 1'b0; exp_v[1] = {1'b1, 5'd0};
    do_reset();
    out_ready5 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      in_valid5 = 1'b1; a5 = va[k]; b5 = vb[k]; cin5 = vc[k];
      tick();
      in_valid5 = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if ({out_valid5, cout5, sum5} !== {1'b1, exp_v[k]}) begin
        failures++;
        $display("FAIL w5_result[%0d]: got valid=%0b cout=%0b sum=%0d want 1 %0b %0d",
                 k, out_valid5, cout5, sum5, exp_v[k][W5], exp_v[k][W5-1:0]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_s [3];
    int idx;
    exp_s[0] = 32'd3; exp_s[1] = 32'd7; exp_s[2] = 32'd11;
    do_reset();
    out_ready = 1'b0; cin = 1'b0;
    in_valid = 1'b1; a = 32'd1; b = 32'd2;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept1: got %0b want 1", in_ready); end
    tick();
    a = 32'd3; b = 32'd4;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept2: got %0b want 1", in_ready); end
    tick();
    a = 32'd5; b = 32'd6;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, sum} !== {1'b0, 1'b1, 32'd3}) begin
        failures++;
        $display("FAIL bp_stall[%0d]: got rdy=%0b valid=%0b sum=%0d want 0 1 3",
                 k, in_ready, out_valid, sum);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    idx = 0;
    for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (sum !== exp_s[idx]) begin
          failures++;
          $display("FAIL bp_order[%0d]: got %0d want %0d", idx, sum, exp_s[idx]);
        end
        idx++;
      end
      tick();
      in_valid = 1'b0;
    end
    checks++;
    if (idx !== 3) begin failures++; $display("FAIL bp_count: got %0d results want 3", idx); end
  endtask

  task automatic test_full_rate(input int n);
    logic [W:0] q [$];
    logic [W:0] exp_v;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      in_valid = (i < n); a = $urandom; b = $urandom; cin = $urandom_range(1);
      @(negedge clk);
      if (i < n) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL full_rate_ready[%0d]: got %0b want 1", i, in_ready); end
      end
      if (i >= 2) begin
        checks++;
        exp_v = (q.size() > 0) ? q.pop_front() : {(W+1){1'bx}};
        if ({out_valid, cout, sum} !== {1'b1, exp_v}) begin
          failures++;
          $display("FAIL full_rate_out[%0d]: got valid=%0b %0b_%h want 1 %0b_%h",
                   i, out_valid, cout, sum, exp_v[W], exp_v[W-1:0]);
        end
      end
      if (in_valid && in_ready) q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_streaming(input int n_beats);
    logic [W:0] q [$];
    logic [W:0] exp_v, held_v;
    bit held;
    int sent, got, cyc;
    do_reset();
    held = 0; sent = 0; got = 0; cyc = 0; held_v = '0;
    while ((sent < n_beats || q.size() > 0) && cyc < 60000) begin
      in_valid  = (sent < n_beats) && ($urandom_range(99) < 70);
      a = $urandom; b = $urandom; cin = $urandom_range(1);
      out_ready = ($urandom_range(99) < 70);
      @(negedge clk);
      if (held) begin
        checks++;
        if ({out_valid, cout, sum} !== {1'b1, held_v}) begin
          failures++;
          $display("FAIL stream_hold: got valid=%0b %0b_%h want 1 %0b_%h",
                   out_valid, cout, sum, held_v[W], held_v[W-1:0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: got %0b_%h want no result", cout, sum);
        end else begin
          exp_v = q.pop_front();
          got++;
          if ({cout, sum} !== exp_v) begin
            failures++;
            $display("FAIL stream_data[%0d]: got %0b_%h want %0b_%h",
                     got, cout, sum, exp_v[W], exp_v[W-1:0]);
          end
        end
      end
      held   = out_valid && !out_ready;
      held_v = {cout, sum};
      if (in_valid && in_ready) begin
        q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== n_beats || q.size() != 0) begin
      failures++;
      $display("FAIL stream_count: got %0d results (%0d pending) want %0d", got, q.size(), n_beats);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    out_ready = 1'b0; cin = 1'b0;
    in_valid = 1'b1; a = 32'd100; b = 32'd1;
    tick();
    a = 32'd200; b = 32'd2;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL mid_full: got valid=%0b rdy=%0b want 1 0", out_valid, in_ready);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, cout, sum, in_ready} !== {1'b0, 1'b0, {W{1'b0}}, 1'b1}) begin
      failures++;
      $display("FAIL mid_async_clear: got valid=%0b cout=%0b sum=%h rdy=%0b want 0 0 0 1",
               out_valid, cout, sum, in_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd7; b = 32'd8; cin = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        checks++;
        if ({cout, sum} !== {1'b0, 32'd15}) begin
          failures++;
          $display("FAIL mid_first_result: got %0b_%0d want 0_15", cout, sum);
        end
      end
      tick();
      in_valid = 1'b0;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_timeout: got no result want sum 15"); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid5 = 1'b0; out_ready5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
    test_reset();
    test_carry_chain();
    test_width5();
    test_backpressure();
    test_full_rate(200);
    test_streaming(10000);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
